// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad event queue.
package keypad_pkg;

  // Legal parameter ranges
  localparam int NKEY_MIN  = 2;
  localparam int NKEY_MAX  = 64;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 64;

  // Key-code width: smallest field that holds every key index 0..nkey-1
  function automatic int code_width(input int nkey);
    return $clog2(nkey);
  endfunction

  // True when the depth is a power of two inside the legal range
  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a flush port.
// Pointers carry one extra wrap bit so full/empty/count fall out of a subtract.
module sync_fifo_fwft #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        push, pop;

  // Full/empty from pointer compare; a push is accepted while full if a pop frees a slot
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    pop     = rd_en & ~empty;
    push    = wr_en & (~full | rd_en);
    rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Storage and pointers; flush wins over push and pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad event queue: synchronises raw key lines, detects presses, keeps a
// sticky status word and queues key codes in press order for the CPU.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int NKEY        = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NKEY-1:0]           key_in,
  input  logic                      clear_all,
  input  logic                      clr_we,
  input  logic [NKEY-1:0]           clr_mask,
  output logic [NKEY-1:0]           key_status,
  input  logic                      rd_en,
  output logic [$clog2(NKEY)-1:0]   rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      irq
);

  localparam int CW = code_width(NKEY);

  if (NKEY < NKEY_MIN || NKEY > NKEY_MAX || !depth_ok(DEPTH) ||
      SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_params
    $error("keypad_event_queue: parameter out of range");
  end

  logic [SYNC_STAGES-1:0][NKEY-1:0] sync_q;
  logic [NKEY-1:0]                  sync_s, prev, rise;
  logic [NKEY-1:0]                  pending, sel_bit, clr_vec;
  logic [CW-1:0]                    sel_code;
  logic                             push_vld, full, empty, drop;

  // Synchroniser chain per key line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= key_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synchronised value for edge detection; not touched by clear_all
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev <= '0;
    else       prev <= sync_s;
  end

  // Rising edges, lowest-index pending selection and overflow detection
  always_comb begin
    sync_s   = sync_q[SYNC_STAGES-1];
    rise     = sync_s & ~prev;
    sel_bit  = pending & (~pending + 1'b1);
    push_vld = |pending;
    sel_code = '0;
    for (int i = 0; i < NKEY; i++)
      if (sel_bit[i]) sel_code = sel_code | CW'(i);
    clr_vec  = clr_we ? clr_mask : '0;
    drop     = push_vld & full & ~rd_en & ~clear_all;
  end

  // Sticky status: a rise beats a per-key clear, clear_all beats everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          key_status <= '0;
    else if (clear_all) key_status <= '0;
    else                key_status <= (key_status & ~clr_vec) | rise;
  end

  // Pending events: the selected bit retires each cycle whether or not it fit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          pending <= '0;
    else if (clear_all) pending <= '0;
    else                pending <= (pending & ~sel_bit) | rise;
  end

  // Sticky overflow and registered interrupt
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (clear_all) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      irq <= rd_valid | overflow;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (clear_all),
    .wr_en   (push_vld),
    .wr_data (sel_code),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count)
  );

  // FIFO non-empty is the CPU-visible valid
  always_comb rd_valid = ~empty;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Scenario bench for keypad_event_queue: expected key codes are queued when
// presses are driven and checked as the FIFO is drained.
module tb_keypad_event_queue;

  localparam int NKEY  = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(NKEY);
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NKEY-1:0] key_in;
  logic            clear_all, clr_we, rd_en;
  logic [NKEY-1:0] clr_mask;
  logic [NKEY-1:0] key_status;
  logic [CW-1:0]   rd_data;
  logic            rd_valid, overflow, irq;
  logic [CNTW-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  keypad_event_queue #(.NKEY(NKEY), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in), .clear_all(clear_all),
    .clr_we(clr_we), .clr_mask(clr_mask), .key_status(key_status),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear_all();
    clear_all = 1'b1;
    tick(1);
    clear_all = 1'b0;
    exp_q.delete();
  endtask

  // Pop every expected entry, comparing the FWFT head before each pop
  task automatic drain(input string name);
    int exp;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      vectors++;
      if (rd_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s rd_valid: got %b want 1 (code %0d pending)", name, rd_valid, exp);
        exp_q.delete();
      end else begin
        vectors++;
        if (rd_data !== CW'(exp)) begin
          miscompares++;
          $display("FAIL %s rd_data: got %0d want %0d", name, rd_data, exp);
        end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    end
    vectors++;
    if (count !== '0) begin
      miscompares++;
      $display("FAIL %s count after drain: got %0d want 0", name, count);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; key_in = '0; clear_all = 0; clr_we = 0; clr_mask = '0; rd_en = 0;
    tick(2);
    vectors++;
    if ({key_status, rd_valid, rd_data, count, overflow, irq} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: status=%h valid=%b data=%0d count=%0d ovf=%b irq=%b want all 0",
               key_status, rd_valid, rd_data, count, overflow, irq);
    end
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_single_press();
    key_in[5] = 1'b1;
    exp_q.push_back(5);
    tick(2);
    vectors++;
    if (key_status !== '0) begin
      miscompares++; $display("FAIL single status early: got %h want 0000", key_status);
    end
    tick(1);
    vectors++;
    if (key_status !== 16'h0020) begin
      miscompares++; $display("FAIL single status: got %h want 0020", key_status);
    end
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL single rd_valid early: got %b want 0", rd_valid);
    end
    tick(1);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== CW'(5) || count !== CNTW'(1)) begin
      miscompares++;
      $display("FAIL single fifo: valid=%b data=%0d count=%0d want 1/5/1", rd_valid, rd_data, count);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL single irq early: got %b want 0", irq);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL single irq: got %b want 1", irq);
    end
    key_in[5] = 1'b0;
    drain("single");
    tick(2);
    pulse_clear_all();
  endtask

  task automatic test_simultaneous();
    key_in[9] = 1'b1; key_in[2] = 1'b1;
    exp_q.push_back(2); exp_q.push_back(9);
    tick(4);
    vectors++;
    if (rd_data !== CW'(2) || count !== CNTW'(1)) begin
      miscompares++; $display("FAIL simul first: data=%0d count=%0d want 2/1", rd_data, count);
    end
    tick(1);
    vectors++;
    if (count !== CNTW'(2)) begin
      miscompares++; $display("FAIL simul count: got %0d want 2", count);
    end
    drain("simul");
    key_in = '0;
    tick(3);
    pulse_clear_all();
  endtask

  task automatic test_clr_mask();
    key_in[5] = 1'b1;
    exp_q.push_back(5);
    tick(2);
    clr_we = 1'b1; clr_mask = 16'h0020;
    tick(1);
    clr_we = 1'b0;
    vectors++;
    if (key_status !== 16'h0020) begin
      miscompares++; $display("FAIL clr set-wins: got %h want 0020", key_status);
    end
    tick(1);
    clr_we = 1'b1;
    tick(1);
    clr_we = 1'b0; clr_mask = '0;
    vectors++;
    if (key_status !== 16'h0000) begin
      miscompares++; $display("FAIL clr plain: got %h want 0000", key_status);
    end
    drain("clr");
    key_in = '0;
    tick(3);
  endtask

  task automatic test_overflow();
    key_in[8:0] = 9'h1FF;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
    tick(14);
    vectors++;
    if (count !== CNTW'(8) || overflow !== 1'b1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf full: count=%0d ovf=%b irq=%b want 8/1/1", count, overflow, irq);
    end
    // Press key 10 and pop the head in the very cycle its push occurs
    key_in[10] = 1'b1;
    tick(3);
    vectors++;
    if (rd_data !== CW'(exp_q[0])) begin
      miscompares++; $display("FAIL ovf head: got %0d want %0d", rd_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(10);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    vectors++;
    if (count !== CNTW'(8)) begin
      miscompares++; $display("FAIL ovf pop+push count: got %0d want 8", count);
    end
    vectors++;
    if (key_status !== 16'h05FF) begin
      miscompares++; $display("FAIL ovf status: got %h want 05ff", key_status);
    end
    drain("ovf");
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf sticky: got %b want 1", overflow);
    end
    key_in = '0;
    tick(4);
  endtask

  task automatic test_clear_all();
    key_in[1] = 1'b1;
    tick(5);
    vectors++;
    if (count !== CNTW'(1)) begin
      miscompares++; $display("FAIL clrall setup count: got %0d want 1", count);
    end
    key_in[4] = 1'b1;
    tick(2);
    clear_all = 1'b1; rd_en = 1'b1;
    tick(1);
    clear_all = 1'b0; rd_en = 1'b0;
    exp_q.delete();
    vectors++;
    if (count !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || key_status !== '0) begin
      miscompares++;
      $display("FAIL clrall: count=%0d valid=%b ovf=%b status=%h want 0/0/0/0000",
               count, rd_valid, overflow, key_status);
    end
    tick(3);
    vectors++;
    if (count !== '0 || irq !== 1'b0) begin
      miscompares++; $display("FAIL clrall dropped rise: count=%0d irq=%b want 0/0", count, irq);
    end
    key_in = '0;
    tick(3);
  endtask

  task automatic test_reset_mid_queue();
    key_in[2:0] = 3'b111;
    tick(8);
    vectors++;
    if (count !== CNTW'(3)) begin
      miscompares++; $display("FAIL rstmid setup count: got %0d want 3", count);
    end
    key_in = 16'h0001;
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({key_status, rd_valid, rd_data, count, overflow, irq} !== '0) begin
      miscompares++;
      $display("FAIL rstmid async: status=%h valid=%b data=%0d count=%0d ovf=%b irq=%b want all 0",
               key_status, rd_valid, rd_data, count, overflow, irq);
    end
    exp_q.delete();
    tick(1);
    rstn = 1'b1;
    exp_q.push_back(0);
    tick(5);
    vectors++;
    if (count !== CNTW'(1) || key_status !== 16'h0001) begin
      miscompares++; $display("FAIL rstmid event: count=%0d status=%h want 1/0001", count, key_status);
    end
    drain("rstmid");
    tick(4);
    vectors++;
    if (count !== '0 || rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid single event: count=%0d valid=%b want 0/0", count, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_clr_mask();
    test_overflow();
    test_clear_all();
    test_reset_mid_queue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
